// File: rtl/motion_update_scheduler.sv
// Walks every cell of the grid, streams its particles to the motion update unit,
// and broadcasts returned results to all caches until every issued particle has come back.
module motion_update_scheduler #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 8,
  parameter int CELL_ID_WIDTH = 4,
  parameter int X_DIM         = 4,
  parameter int Y_DIM         = 4,
  parameter int Z_DIM         = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic [3*CELL_ID_WIDTH-1:0] out_rd_cell,
  output logic [ADDR_WIDTH-1:0]      out_rd_address,
  output logic                       out_rden,
  input  logic [3*DATA_WIDTH-1:0]    in_rd_data,
  output logic                       out_mu_valid,
  output logic [3*DATA_WIDTH-1:0]    out_mu_data,
  input  logic                       in_mu_valid,
  input  logic [3*DATA_WIDTH-1:0]    in_mu_data,
  input  logic [3*CELL_ID_WIDTH-1:0] in_mu_dst_cell,
  output logic                       out_motion_update_enable,
  output logic [3*DATA_WIDTH-1:0]    out_bcast_data,
  output logic [3*CELL_ID_WIDTH-1:0] out_bcast_dst_cell,
  output logic                       out_bcast_valid,
  output logic                       out_busy,
  output logic                       out_done
);

  typedef enum logic [2:0] {
    IDLE, RD_NUM, WAIT_NUM, RD_PART, NEXT_CELL, DRAIN, FLUSH, DONE
  } state_t;

  localparam logic [CELL_ID_WIDTH-1:0] ONE  = CELL_ID_WIDTH'(1);
  localparam logic [CELL_ID_WIDTH-1:0] XMAX = CELL_ID_WIDTH'(X_DIM);
  localparam logic [CELL_ID_WIDTH-1:0] YMAX = CELL_ID_WIDTH'(Y_DIM);
  localparam logic [CELL_ID_WIDTH-1:0] ZMAX = CELL_ID_WIDTH'(Z_DIM);

  state_t                     state_q;
  logic [CELL_ID_WIDTH-1:0]   cx_q, cy_q, cz_q, cx_d, cy_d, cz_d;
  logic                       last_cell;
  logic [ADDR_WIDTH-1:0]      addr_q, num_q;
  logic                       rden_q, en_q, busy_q, done_q, wait_q;
  logic [1:0]                 flush_q;
  logic                       p1_q, p2_q;
  logic [15:0]                issued_q, returned_q;
  logic                       bvalid_q;
  logic [3*DATA_WIDTH-1:0]    bdata_q;
  logic [3*CELL_ID_WIDTH-1:0] bcell_q;

  // z-major cell walk with carry into y, then x
  always_comb begin
    last_cell = (cx_q == XMAX) && (cy_q == YMAX) && (cz_q == ZMAX);
    cx_d = cx_q;
    cy_d = cy_q;
    cz_d = cz_q + ONE;
    if (cz_q == ZMAX) begin
      cz_d = ONE;
      cy_d = cy_q + ONE;
      if (cy_q == YMAX) begin
        cy_d = ONE;
        cx_d = cx_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cx_q       <= ONE;
      cy_q       <= ONE;
      cz_q       <= ONE;
      addr_q     <= '0;
      num_q      <= '0;
      rden_q     <= 1'b0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wait_q     <= 1'b0;
      flush_q    <= '0;
      p1_q       <= 1'b0;
      p2_q       <= 1'b0;
      issued_q   <= '0;
      returned_q <= '0;
      bvalid_q   <= 1'b0;
      bdata_q    <= '0;
      bcell_q    <= '0;
    end else begin
      // Particle reads (not count reads) are tracked through the 2-cycle cache latency
      p1_q <= rden_q && (state_q == RD_PART);
      p2_q <= p1_q;
      if (p2_q)               issued_q   <= issued_q + 16'd1;
      if (in_mu_valid && en_q) returned_q <= returned_q + 16'd1;

      bvalid_q <= in_mu_valid && en_q;
      if (in_mu_valid && en_q) begin
        bdata_q <= in_mu_data;
        bcell_q <= in_mu_dst_cell;
      end

      case (state_q)
        IDLE: if (start) begin
          state_q <= RD_NUM;
          cx_q    <= ONE;
          cy_q    <= ONE;
          cz_q    <= ONE;
          en_q    <= 1'b1;
          busy_q  <= 1'b1;
          rden_q  <= 1'b1;
          addr_q  <= '0;
        end
        RD_NUM: begin
          rden_q  <= 1'b0;
          wait_q  <= 1'b0;
          state_q <= WAIT_NUM;
        end
        WAIT_NUM: begin
          wait_q <= 1'b1;
          if (wait_q) begin
            num_q <= in_rd_data[ADDR_WIDTH-1:0];
            if (in_rd_data[ADDR_WIDTH-1:0] == '0) begin
              state_q <= NEXT_CELL;
            end else begin
              state_q <= RD_PART;
              rden_q  <= 1'b1;
              addr_q  <= ADDR_WIDTH'(1);
            end
          end
        end
        RD_PART: begin
          if (addr_q == num_q) begin
            rden_q  <= 1'b0;
            state_q <= NEXT_CELL;
          end else begin
            addr_q <= addr_q + ADDR_WIDTH'(1);
          end
        end
        NEXT_CELL: begin
          if (last_cell) begin
            state_q <= DRAIN;
          end else begin
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            cz_q    <= cz_d;
            rden_q  <= 1'b1;
            addr_q  <= '0;
            state_q <= RD_NUM;
          end
        end
        DRAIN: if (!p1_q && !p2_q && (returned_q == issued_q)) begin
          en_q    <= 1'b0;
          flush_q <= '0;
          state_q <= FLUSH;
        end
        FLUSH: begin
          flush_q <= flush_q + 2'd1;
          if (flush_q == 2'd2) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q     <= 1'b0;
          busy_q     <= 1'b0;
          issued_q   <= '0;
          returned_q <= '0;
          cx_q       <= ONE;
          cy_q       <= ONE;
          cz_q       <= ONE;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_rd_cell              = busy_q ? {cx_q, cy_q, cz_q} : '0;
  assign out_rd_address           = addr_q;
  assign out_rden                 = rden_q;
  assign out_mu_valid             = p2_q;
  assign out_mu_data              = p2_q ? in_rd_data : '0;
  assign out_motion_update_enable = en_q;
  assign out_bcast_valid          = bvalid_q;
  assign out_bcast_data           = bdata_q;
  assign out_bcast_dst_cell       = bcell_q;
  assign out_busy                 = busy_q;
  assign out_done                 = done_q;

endmodule

// File: tb/tb_motion_update_scheduler.sv
// Scoreboard bench: cache and motion-update-unit models feed the scheduler on a 2x2x2 grid.
module tb_motion_update_scheduler;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [3*CW-1:0] out_rd_cell;
  logic [AW-1:0]   out_rd_address;
  logic            out_rden;
  logic [3*DW-1:0] in_rd_data;
  logic            out_mu_valid;
  logic [3*DW-1:0] out_mu_data;
  logic            in_mu_valid;
  logic [3*DW-1:0] in_mu_data;
  logic [3*CW-1:0] in_mu_dst_cell;
  logic            out_motion_update_enable;
  logic [3*DW-1:0] out_bcast_data;
  logic [3*CW-1:0] out_bcast_dst_cell;
  logic            out_bcast_valid;
  logic            out_busy;
  logic            out_done;

  logic            model_v, inj_v;
  logic [3*DW-1:0] model_d, inj_d;
  logic [3*CW-1:0] model_c, inj_c;
  assign in_mu_valid    = model_v | inj_v;
  assign in_mu_data     = inj_v ? inj_d : model_d;
  assign in_mu_dst_cell = inj_v ? inj_c : model_c;

  motion_update_scheduler #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CELL_ID_WIDTH(CW),
    .X_DIM(2), .Y_DIM(2), .Z_DIM(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .out_rd_cell(out_rd_cell), .out_rd_address(out_rd_address), .out_rden(out_rden),
    .in_rd_data(in_rd_data),
    .out_mu_valid(out_mu_valid), .out_mu_data(out_mu_data),
    .in_mu_valid(in_mu_valid), .in_mu_data(in_mu_data), .in_mu_dst_cell(in_mu_dst_cell),
    .out_motion_update_enable(out_motion_update_enable),
    .out_bcast_data(out_bcast_data), .out_bcast_dst_cell(out_bcast_dst_cell),
    .out_bcast_valid(out_bcast_valid), .out_busy(out_busy), .out_done(out_done)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0, n_pass = 0;
  int unsigned cyc = 0;
  int unsigned cnt_mode = 0;
  bit          hold_last = 1'b0;
  int unsigned exp_total = 0;
  int unsigned mu_seen = 0, bcast_seen = 0, done_seen = 0;

  typedef struct { int unsigned due; logic [3*DW-1:0] d; } mu_t;
  typedef struct { int unsigned due; logic [3*DW-1:0] d; logic [3*CW-1:0] c; } echo_t;
  mu_t                   exp_mu[$];
  echo_t                 echo_q[$];
  logic [3*CW+3*DW-1:0]  exp_bc[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] count_of(input logic [3*CW-1:0] c);
    case (cnt_mode)
      0:       return 8'd3;
      1:       return (c == 12'h121) ? 8'd0 : 8'd2;
      2:       return 8'd0;
      default: return 8'd2;
    endcase
  endfunction

  function automatic logic [3*DW-1:0] cache_word(input logic [3*CW-1:0] c, input logic [AW-1:0] a);
    if (a == '0) return 96'(count_of(c));
    return {16'hA000, 4'h0, c, 24'h0, a, 32'h1234_0000 + {20'h0, c} * 32'h100 + {24'h0, a}};
  endfunction

  // Cache model: data appears two cycles after the read is presented
  logic [3*DW-1:0] rd_pipe;
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_pipe <= out_rden ? cache_word(out_rd_cell, out_rd_address) : '0;
    in_rd_data <= rd_pipe;
  end

  always @(negedge clk) begin
    if (rst) begin
      exp_mu.delete();
      echo_q.delete();
      exp_bc.delete();
      model_v = 1'b0;
    end else begin
      if (out_bcast_valid) begin
        bcast_seen++;
        if (exp_bc.size() == 0) check("bcast_extra", out_bcast_valid, 0);
        else check("bcast", {out_bcast_dst_cell, out_bcast_data}, exp_bc.pop_front());
      end
      if (out_mu_valid) begin
        mu_t m;
        echo_t e;
        mu_seen++;
        if (exp_mu.size() == 0) check("mu_extra", out_mu_valid, 0);
        else begin
          m = exp_mu.pop_front();
          check("mu_data", out_mu_data, m.d);
          check("mu_lat", cyc, m.due);
        end
        e.due = cyc + ((hold_last && mu_seen == exp_total) ? 25 : 5);
        e.d   = ~out_mu_data;
        e.c   = {out_mu_data[67:64], out_mu_data[75:68]};
        echo_q.push_back(e);
      end
      if (out_rden && out_rd_address != '0) begin
        mu_t m;
        m.due = cyc + 2;
        m.d   = cache_word(out_rd_cell, out_rd_address);
        exp_mu.push_back(m);
      end
      if (out_done) done_seen++;
      if (echo_q.size() > 0 && echo_q[0].due <= cyc) begin
        echo_t e;
        e = echo_q.pop_front();
        model_v = 1'b1;
        model_d = e.d;
        model_c = e.c;
        exp_bc.push_back({e.c, e.d});
        check("en_at_ret", out_motion_update_enable, 1);
      end else begin
        model_v = 1'b0;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctrl"}, {out_rd_cell, out_rd_address, out_rden, out_mu_valid,
          out_motion_update_enable, out_bcast_valid, out_busy, out_done, out_bcast_dst_cell}, 0);
    check({tag, "_mu_data"}, out_mu_data, 0);
    check({tag, "_bc_data"}, out_bcast_data, 0);
  endtask

  task automatic run_pass(input int unsigned mode, input bit hold, input bit extra_start);
    int unsigned en_fall, done_cyc;
    bit got;
    cnt_mode  = mode;
    hold_last = hold;
    exp_total = 0;
    for (int x = 1; x <= 2; x++)
      for (int y = 1; y <= 2; y++)
        for (int z = 1; z <= 2; z++)
          exp_total += int'(count_of({4'(x), 4'(y), 4'(z)}));
    mu_seen = 0; bcast_seen = 0; done_seen = 0;
    en_fall = 0; done_cyc = 0; got = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("en_start", {out_motion_update_enable, out_busy}, 2'b11);
    for (int i = 0; i < 3000; i++) begin
      step();
      if (extra_start) start = (i >= 10 && i < 12);
      if (en_fall == 0 && !out_motion_update_enable) en_fall = cyc;
      if (out_done) begin
        done_cyc = cyc;
        got = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (!got) check("done_timeout", got, 1);
    else check("flush_len", done_cyc - en_fall, 3);
    repeat (3) step();
    check("done_once", done_seen, 1);
    check("mu_cnt", mu_seen, exp_total);
    check("bc_cnt", bcast_seen, exp_total);
    check("q_empty", exp_mu.size() + echo_q.size() + exp_bc.size(), 0);
    check("idle_out", {out_motion_update_enable, out_busy}, 2'b00);
  endtask

  initial begin
    int unsigned saved;
    bit seen;
    rst = 1'b1; start = 1'b0; inj_v = 1'b0; inj_d = '0; inj_c = '0;
    model_d = '0; model_c = '0;
    repeat (3) step();
    check_zero("reset");
    rst = 1'b0;
    step();

    run_pass(0, 1'b0, 1'b0);
    check("total_037", exp_total, 24);
    run_pass(1, 1'b0, 1'b0);
    run_pass(2, 1'b0, 1'b0);
    run_pass(3, 1'b1, 1'b0);

    cnt_mode = 0; hold_last = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (out_rden && out_rd_address == 8'd2) begin
        seen = 1'b1;
        break;
      end
    end
    check("rd_part_seen", seen, 1);
    rst = 1'b1;
    #1;
    check_zero("midrst");
    repeat (3) step();
    rst = 1'b0;
    step();
    run_pass(0, 1'b0, 1'b0);

    run_pass(3, 1'b0, 1'b1);
    saved = bcast_seen;
    inj_d = 96'hDEAD_BEEF; inj_c = 12'h222;
    inj_v = 1'b1;
    repeat (3) step();
    inj_v = 1'b0;
    repeat (3) step();
    check("idle_drop", bcast_seen, saved);
    check("idle_busy", out_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/motion_update_scheduler.md
MOTION_UPDATE_SCHEDULER -- requirements
Module: motion_update_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of one velocity/position component.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, cell memory address width.
REQ-003 SHALL have parameter CELL_ID_WIDTH, default 4, width of one cell coordinate.
REQ-004 SHALL have parameters X_DIM, Y_DIM, Z_DIM, default 4 each, cell grid size; coordinates run 1..DIM.
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-007 SHALL have port start, input, 1, one-cycle pulse that begins a motion update pass.
REQ-008 SHALL have port out_rd_cell, output, 3*CELL_ID_WIDTH, cell selected for reading, {x,y,z}.
REQ-009 SHALL have port out_rd_address, output, ADDR_WIDTH, read address to the selected cell.
REQ-010 SHALL have port out_rden, output, 1, read enable to the selected cell.
REQ-011 SHALL have port in_rd_data, input, 3*DATA_WIDTH, muxed cache readout, 2-cycle latency after out_rden.
REQ-012 SHALL have port out_mu_valid, output, 1, particle data valid to motion update unit.
REQ-013 SHALL have port out_mu_data, output, 3*DATA_WIDTH, particle data to motion update unit.
REQ-014 SHALL have port in_mu_valid, input, 1, result valid from motion update unit.
REQ-015 SHALL have port in_mu_data, input, 3*DATA_WIDTH, updated particle data.
REQ-016 SHALL have port in_mu_dst_cell, input, 3*CELL_ID_WIDTH, destination cell of the result.
REQ-017 SHALL have port out_motion_update_enable, output, 1, held high for the whole broadcast phase.
REQ-018 SHALL have ports out_bcast_data (3*DATA_WIDTH), out_bcast_dst_cell (3*CELL_ID_WIDTH), out_bcast_valid (1), outputs, broadcast to all caches.
REQ-019 SHALL have port out_busy (1) and out_done (1, one-cycle pulse), outputs.

Function
REQ-020 States SHALL be IDLE, RD_NUM, WAIT_NUM, RD_PART, NEXT_CELL, DRAIN, FLUSH, DONE.
REQ-021 IDLE: start -> RD_NUM, cell = (1,1,1), out_motion_update_enable set high next cycle; start ignored in all other states.
REQ-022 RD_NUM: drive out_rden=1, out_rd_address=0 for one cycle -> WAIT_NUM.
REQ-023 WAIT_NUM: wait 2 cycles, latch in_rd_data[ADDR_WIDTH-1:0] as particle count N; N=0 -> NEXT_CELL, else -> RD_PART with address 1.
REQ-024 RD_PART: issue one read per cycle, addresses 1..N; after address N -> NEXT_CELL.
REQ-025 out_mu_valid SHALL assert exactly 2 cycles after each RD_PART read, out_mu_data = in_rd_data; no read of address 0 produces out_mu_valid.
REQ-026 NEXT_CELL: increment z, wrap to 1 and carry into y, then x; after (X_DIM,Y_DIM,Z_DIM) -> DRAIN, else -> RD_NUM.
REQ-027 A 16-bit issued counter SHALL count out_mu_valid pulses, a 16-bit returned counter SHALL count in_mu_valid pulses during the pass.
REQ-028 Every in_mu_valid while out_motion_update_enable=1 SHALL produce out_bcast_valid=1 one cycle later with registered in_mu_data/in_mu_dst_cell; out_bcast_valid=0 otherwise, data held.
REQ-029 DRAIN: stay until returned == issued and no read in flight -> FLUSH, deasserting out_motion_update_enable on that transition.
REQ-030 in_mu_valid while out_motion_update_enable=0 SHALL be dropped, not broadcast.
REQ-031 FLUSH: hold enable low 3 cycles (caches write count, flip buffers) -> DONE.
REQ-032 DONE: out_done=1 one cycle, counters cleared -> IDLE.
REQ-033 out_busy SHALL be 1 in every state except IDLE.
REQ-034 Simultaneous in_mu_valid and out_mu_valid SHALL both be counted in the same cycle.

Reset
REQ-035 rst SHALL immediately force IDLE, cell (1,1,1), counters 0, and all outputs 0, including mid-pass.
REQ-036 After rst release, behaviour SHALL be identical to power-up; no pending in-flight data is broadcast.

Verification
REQ-037 X/Y/Z_DIM=2, all counts 3, unit echoes with 5-cycle delay -> 24 out_mu_valid, 24 out_bcast_valid, enable high from cycle after start until last result, out_done once.
REQ-038 One cell count 0, others 2 -> that cell gets only the address-0 read, total issued = 2*(cells-1).
REQ-039 All counts 0 -> no out_mu_valid, enter FLUSH directly after last NEXT_CELL, out_done.
REQ-040 Result held back 20 cycles after last issue -> enable stays high in DRAIN until it returns and is broadcast.
REQ-041 rst asserted during RD_PART -> outputs 0 same cycle, later start runs a full clean pass.
REQ-042 start pulsed during busy and in_mu_valid in IDLE -> both ignored, no broadcast.
